serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits (legal range 2..64).
REQ-002 SHALL have port clock, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 SHALL have port clear, input, 1 bit: reset, which is synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 SHALL have port sub, input, 1 bit: 0 selects a+b, 1 selects a-b.
REQ-006 SHALL have ports a and b, each input, WIDTH bits: the operands.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: a one-cycle pulse when the result is valid.
REQ-009 SHALL have port result, output, WIDTH bits: the sum or difference.
REQ-010 SHALL have port cout, output, 1 bit: the final carry out of the MSB.
REQ-011 SHALL have port overflow, output, 1 bit: signed overflow flag (see REQ-026).

Function
REQ-012 SHALL implement a bit-serial adder: one shared generate/propagate/sum bit cell processes one bit per cycle, LSB first.
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with start=1, capture a, b and sub, set carry to sub, load bit counter to 0 and move to RUN.
REQ-015 SHALL, each RUN cycle, drive the cell with x=a_sh[0], y=b_sh[0]^sub_q and c=carry; shift S into the result MSB; shift a_sh and b_sh right; update carry <= G | (P & carry).
REQ-016 SHALL stay in RUN for exactly WIDTH cycles, then move to DONE; the counter is clog2(WIDTH)+1 bits, so the terminal count WIDTH-1 does not wrap.
REQ-017 SHALL hold DONE for one cycle with done=1, then return to IDLE.
REQ-018 SHALL produce latency from the start-accept edge to done high of WIDTH+1 cycles.
REQ-019 SHALL hold busy=1 in RUN and DONE and busy=0 in IDLE.
REQ-020 SHALL ignore start while busy, with no restart and no operand recapture.
REQ-021 SHALL hold result and cout stable from DONE until the next start is accepted; during RUN they show partial shift contents and are not valid.
REQ-022 SHALL accept start asserted in the same cycle done=1 only on the following IDLE cycle, never in DONE.
REQ-023 SHALL let operands change freely after capture without affecting the operation in flight.

Reset
REQ-024 SHALL, on clear=1 at a rising edge, force state to IDLE and set busy=0, done=0, result=0, cout=0, overflow=0, counter=0 and carry=0.
REQ-025 SHALL let clear asserted mid-RUN abort the operation with no done pulse; clear has priority over start in the same cycle.

Configuration
REQ-026 SHALL, with macro SERIAL_ADD_OVF_EN defined, register overflow in DONE as (carry into MSB) XOR (carry out of MSB), capturing the MSB carry-in during the last RUN cycle.
REQ-027 SHALL, without SERIAL_ADD_OVF_EN, tie overflow to constant 0 and generate no MSB carry-in register.

Structure
REQ-028 SHALL place the FSM state enum (IDLE/RUN/DONE) and the default WIDTH constant in shared package serial_add_pkg.
REQ-029 SHALL instantiate exactly one existing B_Cell as the sole arithmetic sub-module, with no behavioural "+" in the datapath.

Verification
REQ-030 SHALL cover: WIDTH=32, a=5, b=3, sub=0, start for 1 cycle -> done at cycle 33, result=8, cout=0, overflow=0.
REQ-031 SHALL cover: a=0xFFFFFFFF, b=1, sub=0 -> result=0, cout=1, overflow=0.
REQ-032 SHALL cover: a=0x7FFFFFFF, b=1, sub=0 with SERIAL_ADD_OVF_EN -> result=0x80000000, overflow=1; without the macro -> overflow=0.
REQ-033 SHALL cover: a=3, b=5, sub=1 -> result=0xFFFFFFFE, cout=0; a=5, b=3, sub=1 -> result=2, cout=1.
REQ-034 SHALL cover: start re-pulsed at cycle 10 of RUN with new operands -> ignored, first result delivered unchanged at cycle 33.
REQ-035 SHALL cover: clear at cycle 15 of RUN -> next cycle busy=0, result=0, no done; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encoding and the default operand width.
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : serial_add_pkg

// File: rtl/serial_add_ctrl_b_cell.sv
// Single-bit generate/propagate/sum cell shared by the serial adder.
module B_Cell (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic g,
    output logic p,
    output logic s
);

    assign g = x & y;
    assign p = x ^ y;
    assign s = p ^ c;

endmodule : B_Cell

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor controller: one B_Cell processes one bit per
// cycle, LSB first. Subtraction is a + ~b + 1 (b inverted, carry seeded to 1).
// Optional signed-overflow flag enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic cell_g, cell_p, cell_s;

    B_Cell u_cell (
        .x (a_sh_q[0]),
        .y (b_sh_q[0] ^ sub_q),
        .c (carry_q),
        .g (cell_g),
        .p (cell_p),
        .s (cell_s)
    );

`ifdef SERIAL_ADD_OVF_EN
    logic msb_cin_q, msb_cin_d;
`endif

    // Next-state, datapath update and status outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        result_d = result_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        msb_cin_d = msb_cin_q;
`endif
        busy = 1'b0;
        done = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    sub_d   = sub;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                result_d = {cell_s, result_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = cell_g | (cell_p & carry_q);
                if (cnt_q == LAST_BIT) begin
                    // Final bit: latch carry-out (and MSB carry-in) so they
                    // stay valid alongside result until the next start.
                    cout_d  = cell_g | (cell_p & carry_q);
`ifdef SERIAL_ADD_OVF_EN
                    msb_cin_d = carry_q;
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous clear
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            result_q <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            msb_cin_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            result_q <= result_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            msb_cin_q <= msb_cin_d;
`endif
        end
    end

    assign result = result_q;
    assign cout   = cout_q;

`ifdef SERIAL_ADD_OVF_EN
    // Both terms are loaded on the final RUN edge, so the flag is valid in
    // DONE and held with result until the next operation completes.
    assign overflow = msb_cin_q ^ cout_q;
`else
    assign overflow = 1'b0;
`endif

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Directed, table-driven bench for serial_add_ctrl (WIDTH=32).
module tb_serial_add_ctrl;

    localparam int unsigned W       = 32;
    localparam int unsigned LATENCY = W + 1;
    localparam int unsigned MAXWAIT = 100;

    logic         clock = 1'b0;
    logic         clear = 1'b0;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, cout, overflow;
    logic [W-1:0] result;

    int unsigned total = 0;
    int unsigned bad   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;   // expected flag when overflow detection is built in
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_ovf(input logic v);
`ifdef SERIAL_ADD_OVF_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one start pulse, scramble operands afterwards, wait for done.
    task automatic run_op(input vec_t v, input string tag);
        int unsigned n;
        a = v.a; b = v.b; sub = v.sub; start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom; b = $urandom; sub = ~v.sub;
        n = 1;
        chk({tag, ".busy_run"}, 64'(busy), 64'd1);
        while (!done && n < MAXWAIT) begin
            tick();
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(LATENCY));
        chk({tag, ".done"},    64'(done), 64'd1);
        chk({tag, ".busy_done"}, 64'(busy), 64'd1);
        chk({tag, ".result"},  64'(result), 64'(v.res));
        chk({tag, ".cout"},    64'(cout), 64'(v.cout));
        chk({tag, ".overflow"}, 64'(overflow), 64'(exp_ovf(v.ovf)));
        tick();
        chk({tag, ".done_pulse"}, 64'(done), 64'd0);
        chk({tag, ".busy_idle"},  64'(busy), 64'd0);
        chk({tag, ".result_hold"}, 64'(result), 64'(v.res));
        chk({tag, ".cout_hold"},   64'(cout), 64'(v.cout));
    endtask

    initial begin
        int unsigned n;
        int unsigned pulses;
        vec_t v;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[8] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[9] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};

        // Reset state
        clear = 1'b1;
        tick();
        tick();
        clear = 1'b0;
        chk("rst.busy",     64'(busy), 64'd0);
        chk("rst.done",     64'(done), 64'd0);
        chk("rst.result",   64'(result), 64'd0);
        chk("rst.cout",     64'(cout), 64'd0);
        chk("rst.overflow", 64'(overflow), 64'd0);
        tick();

        // Table-driven operations
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
            tick();
        end

        // Start re-pulsed mid-RUN with new operands is ignored
        a = 32'd5; b = 32'd3; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < MAXWAIT) begin
            if (n == 10) begin
                a = 32'hAAAA_5555; b = 32'h1234_0000; sub = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        chk("repulse.latency", 64'(n), 64'(LATENCY));
        chk("repulse.result",  64'(result), 64'd8);
        chk("repulse.cout",    64'(cout), 64'd0);
        tick();
        chk("repulse.no_restart", 64'(busy), 64'd0);
        tick();

        // Clear at RUN cycle 15 aborts with no done pulse
        a = 32'h7FFF_FFFF; b = 32'd1; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 15; k++) tick();
        chk("abort.busy_before", 64'(busy), 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("abort.busy",   64'(busy), 64'd0);
        chk("abort.result", 64'(result), 64'd0);
        chk("abort.done",   64'(done), 64'd0);
        chk("abort.cout",   64'(cout), 64'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done) pulses++;
        end
        chk("abort.no_done", 64'(pulses), 64'd0);
        v = '{32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b0};
        run_op(v, "after_abort");
        tick();

        // Clear has priority over start in the same cycle
        a = 32'd1; b = 32'd1; sub = 1'b0; start = 1'b1; clear = 1'b1;
        tick();
        start = 1'b0; clear = 1'b0;
        chk("clr_prio.busy", 64'(busy), 64'd0);
        tick();

        // Start held through DONE is accepted only on the following IDLE cycle
        a = 32'd9; b = 32'd4; sub = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < MAXWAIT) begin
            tick();
            n++;
        end
        chk("b2b.first_latency", 64'(n), 64'(LATENCY));
        chk("b2b.first_result",  64'(result), 64'd5);
        a = 32'd1; b = 32'd1; sub = 1'b0; start = 1'b1;
        tick();
        chk("b2b.idle_gap", 64'(busy), 64'd0);
        tick();
        start = 1'b0;
        chk("b2b.accepted", 64'(busy), 64'd1);
        n = 1;
        while (!done && n < MAXWAIT) begin
            tick();
            n++;
        end
        chk("b2b.second_latency", 64'(n), 64'(LATENCY));
        chk("b2b.second_result",  64'(result), 64'd2);
        chk("b2b.second_cout",    64'(cout), 64'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_add_ctrl
